spad_weight: RTL

Per-PE weight scratchpad. It sits directly downstream of the weight router and captures the filter word stream the router writes (`w_data_spad`/`load_en_spad`) into a local SRAM array. Once a complete kernel_size² filter is held, it serves single-cycle-latency random reads to the PE MAC datapath until the filter is released or overwritten.

---
 rtl/spad_weight_if.sv | 27 ++
 rtl/spad_weight.sv | 120 ++++++++++++
 2 files changed

// File: rtl/spad_weight_if.sv
// rtl/spad_weight_if.sv - weight scratchpad bus: router write stream plus MAC read port
interface spad_weight_if #(
   parameter int DATA_BITWIDTH      = 16,
   parameter int ADDR_BITWIDTH_SPAD = 9
);
   logic [DATA_BITWIDTH-1:0]      w_data_spad;
   logic                          load_en_spad;
   logic                          read_req_spad;
   logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad;
   logic                          release_filt;
   logic [DATA_BITWIDTH-1:0]      r_data_spad;
   logic                          r_valid_spad;
   logic                          filt_ready;
   logic                          load_ovf;

   // Router/MAC side drives the requests and consumes the read data and status.
   modport master (
      output w_data_spad, load_en_spad, read_req_spad, r_addr_spad, release_filt,
      input  r_data_spad, r_valid_spad, filt_ready, load_ovf
   );

   // Scratchpad side.
   modport slave (
      input  w_data_spad, load_en_spad, read_req_spad, r_addr_spad, release_filt,
      output r_data_spad, r_valid_spad, filt_ready, load_ovf
   );
endinterface

// File: rtl/spad_weight.sv
// rtl/spad_weight.sv - per-PE weight scratchpad: captures one filter, serves 1-cycle reads
module spad_weight #(
   parameter int DATA_BITWIDTH      = 16,
   parameter int ADDR_BITWIDTH_SPAD = 9,
   parameter int kernel_size        = 3,
   parameter int W_LOAD_ADDR        = 0
) (
   input logic          clk,
   input logic          reset,
   spad_weight_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_BITWIDTH_SPAD;
   localparam int K2    = kernel_size * kernel_size;
   localparam int CW    = $clog2(K2 + 1);

   localparam logic [ADDR_BITWIDTH_SPAD-1:0] LOAD_ADDR = ADDR_BITWIDTH_SPAD'(W_LOAD_ADDR);
   localparam logic [ADDR_BITWIDTH_SPAD-1:0] ADDR_ONE  = ADDR_BITWIDTH_SPAD'(1);
   localparam logic [CW-1:0]                 CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]                 CNT_LAST  = CW'(K2 - 1);
   // A 1x1 filter is complete on its first word, so the load skips LOADING.
   localparam bit                            SINGLE    = (K2 == 1);

   typedef enum logic [1:0] {EMPTY, LOADING, DRAIN, READY} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_BITWIDTH_SPAD-1:0] wptr_q, wptr_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          ovf_q, ovf_d;
   logic                          we;
   logic [ADDR_BITWIDTH_SPAD-1:0] waddr;
   logic                          rd_accept;
   logic [DATA_BITWIDTH-1:0]      r_data_q;
   logic                          r_valid_q;

   // Storage is deliberately not reset so it can map onto an SRAM macro.
   logic [DATA_BITWIDTH-1:0]      mem [DEPTH];

   // State and load bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         wptr_q  <= LOAD_ADDR;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next state: a load always wins over release; DRAIN swallows the router's trailing cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (bus.load_en_spad) state_d = SINGLE ? DRAIN : LOADING;
         LOADING: if (bus.load_en_spad && cnt_q == CNT_LAST) state_d = DRAIN;
         DRAIN:   if (!bus.load_en_spad) state_d = READY;
         READY: begin
            if (bus.load_en_spad)     state_d = SINGLE ? DRAIN : LOADING;
            else if (bus.release_filt) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Write pointer, word count, overflow flag and read acceptance for the current state.
   always_comb begin
      we     = 1'b0;
      waddr  = wptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      case (state_q)
         EMPTY, READY: begin
            if (bus.load_en_spad) begin
               we     = 1'b1;
               waddr  = LOAD_ADDR;
               wptr_d = LOAD_ADDR + ADDR_ONE;
               cnt_d  = CNT_ONE;
               ovf_d  = 1'b0;
            end
         end
         LOADING: begin
            if (bus.load_en_spad) begin
               we     = 1'b1;
               wptr_d = wptr_q + ADDR_ONE;
               cnt_d  = cnt_q + CNT_ONE;
            end
         end
         DRAIN: begin
            if (bus.load_en_spad) ovf_d = 1'b1;
         end
         default: ;
      endcase
      rd_accept = (state_q == READY) && !bus.load_en_spad && bus.read_req_spad;
   end

   // Array write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= bus.w_data_spad;
   end

   // Registered read port; rejected requests leave the data register untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= rd_accept;
         if (rd_accept) r_data_q <= mem[bus.r_addr_spad];
      end
   end

   assign bus.r_data_spad  = r_data_q;
   assign bus.r_valid_spad = r_valid_q;
   assign bus.filt_ready   = (state_q == READY);
   assign bus.load_ovf     = ovf_q;
endmodule
